// File: rtl/filt_feeder.sv
// ADC-to-filter feeder: one-deep input holding register, a request FSM driving the
// filter engine handshake, and a first-word-fall-through result FIFO.
// Optional drop counter is built only when FILT_FEEDER_DROP_CNT_EN is defined.
module filt_feeder #(
   parameter int DATA_SIZE      = 16,
   parameter int FIFO_ADDR_SIZE = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 adc_valid,
   input  logic [DATA_SIZE-1:0] adc_data,
   output logic                 adc_ready,
   output logic                 filt_start,
   output logic [DATA_SIZE-1:0] filt_val,
   input  logic                 filt_done,
   input  logic [DATA_SIZE-1:0] filt_result,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [15:0]          drop_cnt
);

   localparam int DEPTH = 2**FIFO_ADDR_SIZE;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_START   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_CAPTURE = 2'd3;

   logic [1:0]                state;
   logic                      hold_full;
   logic [DATA_SIZE-1:0]      hold_data;
   logic [15:0]               wait_cnt;
   logic [DATA_SIZE-1:0]      mem [DEPTH];
   logic [FIFO_ADDR_SIZE-1:0] wr_ptr, rd_ptr;
   logic [FIFO_ADDR_SIZE:0]   count;

   logic adc_accept, start_req, push, pop;

   // count tops out at DEPTH, so its MSB alone says "full"
   assign start_req  = (state == S_IDLE) && hold_full && !count[FIFO_ADDR_SIZE];
   assign adc_ready  = ~hold_full;
   assign adc_accept = adc_valid & adc_ready;
   assign push       = (state == S_CAPTURE);
   assign out_valid  = (count != '0);
   assign pop        = out_valid & out_ready;
   assign out_data   = mem[rd_ptr];
   assign filt_start = (state == S_START) || (state == S_WAIT);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         if (start_req)  hold_full <= 1'b0;
         // a fresh load takes priority over the free on the same edge
         if (adc_accept) begin
            hold_full <= 1'b1;
            hold_data <= adc_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         filt_val    <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start_req) begin
               filt_val <= hold_data;
               state    <= S_START;
            end
            S_START: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (filt_done) begin
                  state <= S_CAPTURE;
               end else if (wait_cnt == TO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage is reset so the fall-through head reads 0 before the first push
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= filt_result;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FILT_FEEDER_DROP_CNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         drop_cnt <= '0;
      else if (adc_valid && hold_full && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_filt_feeder.sv
// Randomised scoreboard bench for filt_feeder with a behavioural filter-engine model.
// Expected FIFO output = engine function of each accepted sample, in acceptance order.
module tb_filt_feeder;

   logic        clk = 1'b0;
   logic        rstn;
   logic        adc_valid;
   logic [15:0] adc_data;
   logic        adc_ready;
   logic        filt_start;
   logic [15:0] filt_val;
   logic        filt_done;
   logic [15:0] filt_result;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        timeout_err;
   logic [15:0] drop_cnt;

   filt_feeder #(.DATA_SIZE(16), .FIFO_ADDR_SIZE(4), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .rstn(rstn), .adc_valid(adc_valid), .adc_data(adc_data),
      .adc_ready(adc_ready), .filt_start(filt_start), .filt_val(filt_val),
      .filt_done(filt_done), .filt_result(filt_result), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .busy(busy),
      .timeout_err(timeout_err), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   int          drop_exp = 0;
   bit          expect_timeout = 1'b0;
   int          rdy_mode = 0;        // 0 hold low, 1 hold high, 2 random
   bit          eng_rand = 1'b0;
   logic [31:0] eng_mask = '0;       // bit k: assert done in k-th cycle of filt_start
   int          st_cnt = 0;
   int          cur_len = 0, last_len = 0, pulses = 0;

   function automatic logic [15:0] eng_f(input logic [15:0] x);
      return x ^ 16'h1888;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Filter engine: done after a chosen number of filt_start cycles, result one cycle later
   initial begin
      bit prev_done;
      prev_done   = 1'b0;
      filt_done   = 1'b0;
      filt_result = '0;
      forever begin
         @(posedge clk); #1;
         if (prev_done) filt_result = eng_f(filt_val);
         if (filt_start) begin
            st_cnt++;
            if (st_cnt == 1 && eng_rand) eng_mask = 32'd1 << $urandom_range(2, 8);
         end else begin
            st_cnt = 0;
         end
         filt_done = filt_start && (st_cnt < 32) && eng_mask[st_cnt];
         prev_done = filt_done;
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom % 2) : 1'b0;
      end
   end

   // Acceptance / drop observer, filt_start pulse meter, and output scoreboard
   always @(negedge clk) begin
      if (rstn && adc_valid) begin
         if (adc_ready) begin
            if (!expect_timeout) exp_q.push_back(eng_f(adc_data));
         end else begin
            drop_exp++;
         end
      end
      if (filt_start) cur_len++;
      else if (cur_len != 0) begin
         last_len = cur_len;
         cur_len  = 0;
         pulses++;
      end
      if (rstn && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fifo_unexpected actual=%0h expected=none", out_data);
         end else begin
            chk("fifo_out", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] d);
      int n = 0;
      while (!adc_ready && n < 300) begin @(posedge clk); #1; n++; end
      chk("send_ready", adc_ready, 1);
      adc_valid = 1'b1;
      adc_data  = d;
      @(posedge clk); #1;
      adc_valid = 1'b0;
   endtask

   task automatic wait_pulse(input int p0, input int budget);
      int n = 0;
      while (pulses == p0 && n < budget) begin @(posedge clk); #1; n++; end
      chk("pulse_seen", 32'(pulses != p0), 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
      chk("drain_done", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("fifo_empty", out_valid, 0);
      chk("idle_after_drain", busy, 0);
   endtask

   task automatic chk_drop();
`ifdef FILT_FEEDER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, drop_exp);
`else
      chk("drop_cnt", drop_cnt, 0);
`endif
   endtask

   initial begin
      int p0;
      rstn      = 1'b0;
      adc_valid = 1'b0;
      adc_data  = '0;
      #1;
      chk("rst_adc_ready", adc_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_filt_start", filt_start, 0);
      chk("rst_filt_val", filt_val, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      @(posedge clk); @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Basic request: done in the 11th filt_start cycle
      eng_mask = 32'd1 << 11;
      p0 = pulses;
      send(16'h1234);
      wait_pulse(p0, 60);
      chk("start_len_basic", last_len, 11);
      repeat (3) @(posedge clk);
      #1;
      chk("basic_out_valid", out_valid, 1);
      chk("basic_out_data", out_data, 16'h0ABC);
      drain(50);

      // done in START is ignored; second done in the first WAIT cycle completes
      eng_mask = 32'b110;
      rdy_mode = 0;
      p0 = pulses;
      send(16'h00F0);
      wait_pulse(p0, 40);
      chk("start_len_early_done", last_len, 2);
      drain(50);

      // Engine never answers: timeout after START + 20 WAIT cycles
      eng_mask = '0;
      rdy_mode = 0;
      expect_timeout = 1'b1;
      p0 = pulses;
      send(16'hBEEF);
      expect_timeout = 1'b0;
      wait_pulse(p0, 80);
      chk("start_len_timeout", last_len, 21);
      @(negedge clk);
      chk("timeout_err_set", timeout_err, 1);
      chk("timeout_no_write", out_valid, 0);
      chk("timeout_idle", busy, 0);

      // FIFO fill with consumer stalled: 16 stored, 17th held back
      eng_rand = 1'b1;
      rdy_mode = 0;
      for (int i = 0; i < 17; i++) send(16'($urandom));
      repeat (40) @(posedge clk);
      #1;
      chk("full_out_valid", out_valid, 1);
      chk("full_fsm_idle", busy, 0);
      chk("full_hold_busy", adc_ready, 0);
      chk("full_queued", exp_q.size(), 17);
      drain(600);

      // Continuous samples with an 8-cycle engine: many drops
      eng_rand = 1'b0;
      eng_mask = 32'd1 << 8;
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) begin
         adc_valid = 1'b1;
         adc_data  = 16'($urandom);
         @(posedge clk); #1;
      end
      adc_valid = 1'b0;
      drain(400);
      chk_drop();

      // Randomised traffic
      eng_rand = 1'b1;
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         adc_valid = ($urandom % 3) == 0;
         adc_data  = 16'($urandom);
         @(posedge clk); #1;
      end
      adc_valid = 1'b0;
      drain(800);
      chk_drop();

      // Reset in the middle of a WAIT
      eng_rand = 1'b0;
      eng_mask = 32'd1 << 15;
      rdy_mode = 1;
      send(16'h7777);
      repeat (6) @(posedge clk);
      #3;
      chk("pre_rst_in_wait", filt_start, 1);
      rstn = 1'b0;
      #1;
      exp_q.delete();
      drop_exp = 0;
      chk("mid_rst_filt_start", filt_start, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_adc_ready", adc_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_data", out_data, 0);
      chk("mid_rst_filt_val", filt_val, 0);
      chk("mid_rst_timeout_err", timeout_err, 0);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      eng_mask = 32'd1 << 3;
      p0 = pulses;
      send(16'h5555);
      wait_pulse(p0, 40);
      chk("post_rst_start_len", last_len, 3);
      drain(50);
      chk_drop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
